// File: rtl/tilt_position_ctrl.sv
// Tilt-to-cursor controller: resynchronises signed X/Y tilt words, averages them on a
// fixed tick, applies a dead zone and step scaling, and integrates a saturating cursor.
module tilt_position_ctrl #(
   parameter int TICK_DIV   = 250000,
   parameter int AVG_LOG2   = 2,
   parameter int DEADZONE   = 4,
   parameter int STEP_SHIFT = 3,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479,
   parameter int X_INIT     = 320,
   parameter int Y_INIT     = 240
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        accel_data_x,
   input  logic [7:0]        accel_data_y,
   input  logic              recenter,
   output logic signed [7:0] tilt_x,
   output logic signed [7:0] tilt_y,
   output logic [9:0]        pos_x,
   output logic [9:0]        pos_y,
   output logic              pos_valid
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int SW  = 8 + AVG_LOG2;

   localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
   localparam logic [SCW-1:0] SAMP_LAST = SCW'((1 << AVG_LOG2) - 1);
   localparam logic [8:0]     DZ        = 9'(DEADZONE);
   localparam logic [9:0]     XMAX      = 10'(X_MAX);
   localparam logic [9:0]     YMAX      = 10'(Y_MAX);
   localparam logic [9:0]     XINIT     = 10'(X_INIT);
   localparam logic [9:0]     YINIT     = 10'(Y_INIT);

   logic [7:0]           sync1_x, sync2_x, cap_x;
   logic [7:0]           sync1_y, sync2_y, cap_y;
   logic [TCW-1:0]       tick_cnt;
   logic                 tick;
   logic [SCW-1:0]       samp_cnt;
   logic signed [SW-1:0] sum_x, sum_y;
   logic signed [SW-1:0] cap_ext_x, cap_ext_y;
   logic signed [SW-1:0] avg_full_x, avg_full_y;
   logic signed [7:0]    avg_x, avg_y;
   logic signed [9:0]    step_x, step_y;
   logic                 stage_b, stage_c;

   // Magnitude is formed in 9 bits so -128 scales symmetrically with +128.
   function automatic logic signed [9:0] calc_step(input logic signed [7:0] t);
      logic [8:0] ext, mag, smag;
      ext  = {t[7], t};
      mag  = t[7] ? (~ext + 9'd1) : ext;
      smag = mag >> STEP_SHIFT;
      if (mag <= DZ)
         calc_step = '0;
      else if (t[7])
         calc_step = -$signed({1'b0, smag});
      else
         calc_step = $signed({1'b0, smag});
   endfunction

   function automatic logic [9:0] clamp_pos(input logic [9:0] pos, input logic signed [9:0] step,
                                            input logic neg, input logic [9:0] hi);
      logic signed [11:0] delta, nxt;
      delta = {{2{step[9]}}, step};
      if (neg)
         delta = -delta;
      nxt = $signed({2'b00, pos}) + delta;
      if (nxt < 12'sd0)
         clamp_pos = '0;
      else if (nxt > $signed({2'b00, hi}))
         clamp_pos = hi;
      else
         clamp_pos = nxt[9:0];
   endfunction

   assign tick       = (tick_cnt == TICK_LAST);
   assign cap_ext_x  = SW'($signed(cap_x));
   assign cap_ext_y  = SW'($signed(cap_y));
   assign avg_full_x = sum_x >>> AVG_LOG2;
   assign avg_full_y = sum_y >>> AVG_LOG2;
   assign avg_x      = avg_full_x[7:0];
   assign avg_y      = avg_full_y[7:0];

   // pos_valid is a one-cycle strobe with no back-pressure; pos_x/pos_y hold between strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_x   <= '0;
         sync2_x   <= '0;
         cap_x     <= '0;
         sync1_y   <= '0;
         sync2_y   <= '0;
         cap_y     <= '0;
         tick_cnt  <= '0;
         samp_cnt  <= '0;
         sum_x     <= '0;
         sum_y     <= '0;
         step_x    <= '0;
         step_y    <= '0;
         stage_b   <= 1'b0;
         stage_c   <= 1'b0;
         tilt_x    <= '0;
         tilt_y    <= '0;
         pos_x     <= XINIT;
         pos_y     <= YINIT;
         pos_valid <= 1'b0;
      end else begin
         sync1_x <= accel_data_x;
         sync2_x <= sync1_x;
         sync1_y <= accel_data_y;
         sync2_y <= sync1_y;
         // A word still changing between the two synchroniser stages is a tear; keep the old capture.
         if (sync2_x == sync1_x)
            cap_x <= sync2_x;
         if (sync2_y == sync1_y)
            cap_y <= sync2_y;

         tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
         pos_valid <= 1'b0;

         if (recenter) begin
            pos_x    <= XINIT;
            pos_y    <= YINIT;
            sum_x    <= '0;
            sum_y    <= '0;
            samp_cnt <= '0;
            stage_b  <= 1'b0;
            stage_c  <= 1'b0;
         end else begin
            if (stage_b) begin
               tilt_x   <= avg_x;
               tilt_y   <= avg_y;
               step_x   <= calc_step(avg_x);
               step_y   <= calc_step(avg_y);
               sum_x    <= '0;
               sum_y    <= '0;
               samp_cnt <= '0;
               stage_b  <= 1'b0;
               stage_c  <= 1'b1;
            end else if (tick) begin
               sum_x <= sum_x + cap_ext_x;
               sum_y <= sum_y + cap_ext_y;
               if (samp_cnt == SAMP_LAST)
                  stage_b <= 1'b1;
               else
                  samp_cnt <= samp_cnt + 1'b1;
            end
            // Positive Y tilt moves the cursor up the screen, hence the subtraction.
            if (stage_c) begin
               pos_x     <= clamp_pos(pos_x, step_x, 1'b0, XMAX);
               pos_y     <= clamp_pos(pos_y, step_y, 1'b1, YMAX);
               pos_valid <= 1'b1;
               stage_c   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_tilt_position_ctrl.sv
// Randomised bench for tilt_position_ctrl: drives windows of four tick samples per axis
// and checks every cycle against an arithmetic model of averaging, dead zone and clamping.
module tb_tilt_position_ctrl;

   localparam int TICK_DIV = 16;
   localparam int WIN      = 4 * TICK_DIV;
   localparam int X_MAX    = 639;
   localparam int Y_MAX    = 479;
   localparam int X_INIT   = 320;
   localparam int Y_INIT   = 240;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        accel_data_x;
   logic [7:0]        accel_data_y;
   logic              recenter;
   logic signed [7:0] tilt_x, tilt_y;
   logic [9:0]        pos_x, pos_y;
   logic              pos_valid;

   tilt_position_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .accel_data_x (accel_data_x),
      .accel_data_y (accel_data_y),
      .recenter     (recenter),
      .tilt_x       (tilt_x),
      .tilt_y       (tilt_y),
      .pos_x        (pos_x),
      .pos_y        (pos_y),
      .pos_valid    (pos_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int pos_x_m, pos_y_m, tilt_x_m, tilt_y_m;
   int nxt_pos_x, nxt_pos_y, nxt_tilt_x, nxt_tilt_y;
   bit pend;
   int last_x;
   int win_x[4];
   int win_y[4];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int floor_div4(input int s);
      return (s >= 0) ? s / 4 : -((-s + 3) / 4);
   endfunction

   function automatic int step_of(input int t);
      int m;
      m = (t < 0) ? -t : t;
      if (m <= 4) return 0;
      return (t < 0) ? -(m / 8) : m / 8;
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic set_win(input int x0, x1, x2, x3, y0, y1, y2, y3);
      win_x[0] = x0; win_x[1] = x1; win_x[2] = x2; win_x[3] = x3;
      win_y[0] = y0; win_y[1] = y1; win_y[2] = y2; win_y[3] = y3;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      recenter = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      pos_x_m  = X_INIT;
      pos_y_m  = Y_INIT;
      tilt_x_m = 0;
      tilt_y_m = 0;
      pend     = 1'b0;
      chk("rst_pos_x", int'(pos_x), pos_x_m);
      chk("rst_pos_y", int'(pos_y), pos_y_m);
      chk("rst_tilt_x", int'(tilt_x), 0);
      chk("rst_tilt_y", int'(tilt_y), 0);
      chk("rst_valid", int'(pos_valid), 0);
      rst_n = 1'b1;
   endtask

   // One averaging window: inputs change mid-interval, far from the sampling ticks.
   task automatic run_window(input bit tog_x, input bit rc, input int abort_at);
      bit         valid_m;
      logic [7:0] hv;
      int         sx, sy, ax, ay;
      if (tog_x)
         for (int i = 0; i < 4; i++) win_x[i] = last_x;
      hv = 8'(last_x);
      for (int r = 1; r <= WIN; r++) begin
         if (abort_at != 0 && r == abort_at) begin
            recenter = 1'b0;
            return;
         end
         recenter = rc && (r == 2);
         if (tog_x)
            accel_data_x = (r % 2 == 1) ? ~hv : (hv ^ 8'h55);
         if (r % TICK_DIV == TICK_DIV / 2) begin
            if (!tog_x) begin
               accel_data_x = 8'(win_x[r / TICK_DIV]);
               last_x       = win_x[r / TICK_DIV];
            end
            accel_data_y = 8'(win_y[r / TICK_DIV]);
         end
         @(posedge clk);
         #1;
         valid_m = 1'b0;
         if (r == 1 && pend) begin
            tilt_x_m = nxt_tilt_x;
            tilt_y_m = nxt_tilt_y;
         end
         if (r == 2) begin
            if (rc) begin
               pos_x_m = X_INIT;
               pos_y_m = Y_INIT;
            end else if (pend) begin
               pos_x_m = nxt_pos_x;
               pos_y_m = nxt_pos_y;
               valid_m = 1'b1;
            end
            pend = 1'b0;
         end
         chk("pos_valid", int'(pos_valid), int'(valid_m));
         chk("pos_x", int'(pos_x), pos_x_m);
         chk("pos_y", int'(pos_y), pos_y_m);
         chk("tilt_x", int'(tilt_x), tilt_x_m);
         chk("tilt_y", int'(tilt_y), tilt_y_m);
      end
      recenter = 1'b0;
      sx = 0;
      sy = 0;
      for (int i = 0; i < 4; i++) begin
         sx += win_x[i];
         sy += win_y[i];
      end
      ax         = floor_div4(sx);
      ay         = floor_div4(sy);
      nxt_tilt_x = ax;
      nxt_tilt_y = ay;
      nxt_pos_x  = clampi(pos_x_m + step_of(ax), X_MAX);
      nxt_pos_y  = clampi(pos_y_m - step_of(ay), Y_MAX);
      pend       = 1'b1;
   endtask

   function automatic int rnd_s8();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      return int'($signed(b));
   endfunction

   initial begin
      rst_n        = 1'b0;
      recenter     = 1'b0;
      accel_data_x = '0;
      accel_data_y = '0;
      last_x       = 0;
      do_reset();

      // steady +40 on X
      set_win(40, 40, 40, 40, 0, 0, 0, 0);
      repeat (3) run_window(1'b0, 1'b0, 0);

      // dead zone on both sides
      set_win(3, 3, 3, 3, 0, 0, 0, 0);
      run_window(1'b0, 1'b0, 0);
      set_win(-4, -4, -4, -4, 0, 0, 0, 0);
      run_window(1'b0, 1'b0, 0);

      // saturation at each bound
      set_win(-128, -128, -128, -128, 0, 0, 0, 0);
      repeat (24) run_window(1'b0, 1'b0, 0);
      chk("x_floor", int'(pos_x), 0);
      set_win(0, 0, 0, 0, 127, 127, 127, 127);
      repeat (20) run_window(1'b0, 1'b0, 0);
      chk("y_floor", int'(pos_y), 0);
      set_win(0, 0, 0, 0, -128, -128, -128, -128);
      repeat (34) run_window(1'b0, 1'b0, 0);
      chk("y_ceiling", int'(pos_y), Y_MAX);

      // alternating samples cancel; a toggling input is never captured
      set_win(40, -40, 40, -40, -40, 40, -40, 40);
      repeat (2) run_window(1'b0, 1'b0, 0);
      chk("alt_tilt_x", int'(tilt_x), 0);
      set_win(25, 25, 25, 25, 0, 0, 0, 0);
      run_window(1'b0, 1'b0, 0);
      repeat (2) run_window(1'b1, 1'b0, 0);

      // recenter on the stage C edge
      do_reset();
      set_win(40, 40, 40, 40, 0, 0, 0, 0);
      repeat (17) run_window(1'b0, 1'b0, 0);
      chk("pos_x_400", int'(pos_x), 400);
      run_window(1'b0, 1'b1, 0);
      chk("recentered_x", int'(pos_x), X_INIT);

      // reset after two of four samples discards them
      set_win(127, 127, 127, 127, -100, -100, -100, -100);
      run_window(1'b0, 1'b0, 41);
      do_reset();
      set_win(40, 40, 40, 40, 0, 0, 0, 0);
      repeat (2) run_window(1'b0, 1'b0, 0);
      chk("post_rst_tilt", int'(tilt_x), 40);
      chk("post_rst_pos", int'(pos_x), 325);

      // random windows with occasional toggling and recenter
      for (int w = 0; w < 40; w++) begin
         int  mode;
         mode = int'($urandom_range(0, 9));
         set_win(rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8());
         run_window(mode == 0, mode == 1, 0);
      end
      run_window(1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
